rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DOMAINS, default 3, giving the number of sequenced domain resets (legal range 1..8).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4, giving the minimum cycles all domains stay asserted (legal range 1..255).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 8, giving the cycles between successive domain releases (legal range 1..255).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-low, driven by the synchronized reset of the CLK domain.
REQ-006 The block SHALL have port sw_rst_req, input, 1 bit: single-cycle software reset request.
REQ-007 The block SHALL have port sw_rst_ack, output, 1 bit: one-cycle pulse acknowledging an accepted request.
REQ-008 The block SHALL have port dom_rst_n, output, NUM_DOMAINS bits: active-low domain resets; bit 0 releases first.
REQ-009 The block SHALL have port busy, output, 1 bit: high while any domain is held in reset.
REQ-010 The block SHALL have port seq_done, output, 1 bit: high when all domains are released.

Function
REQ-011 The FSM SHALL have three states: ASSERT (all dom_rst_n low), RELEASE (domains released one by one), and DONE (all released).
REQ-012 A single timer SHALL load HOLD_CYCLES-1 on entry to ASSERT and GAP_CYCLES-1 after each release, decrementing once per cycle.
REQ-013 The ASSERT-to-RELEASE transition SHALL occur on the edge where the timer reads 0; that same edge SHALL set dom_rst_n[0] high.
REQ-014 In RELEASE, a domain index SHALL advance on timer expiry, setting dom_rst_n[idx] high on that edge; released bits SHALL stay high.
REQ-015 Setting dom_rst_n[k] SHALL occur on clock edge HOLD_CYCLES + k*GAP_CYCLES, counting the first edge after RST deassertion as edge 1.
REQ-016 The FSM SHALL enter DONE on the edge releasing dom_rst_n[NUM_DOMAINS-1]; seq_done SHALL rise and busy SHALL fall on that same edge.
REQ-017 When NUM_DOMAINS is 1, the FSM SHALL go from ASSERT directly to DONE, with no GAP wait.
REQ-018 An sw_rst_req sampled high in DONE SHALL, on the next edge, drive all dom_rst_n low, enter ASSERT, reload the timer, and pulse sw_rst_ack for one cycle.
REQ-019 An sw_rst_req sampled high in RELEASE SHALL abort the sequence: all dom_rst_n low, index cleared, ASSERT entered, and sw_rst_ack pulsed on the next edge.
REQ-020 An sw_rst_req sampled high in ASSERT SHALL be acknowledged, with sw_rst_ack pulsed, and SHALL restart the hold timer at HOLD_CYCLES-1.
REQ-021 sw_rst_req held high for several cycles SHALL be treated as one request per cycle; each cycle restarts the hold, and release begins only after the request drops.
REQ-022 sw_rst_ack SHALL never be high for two consecutive cycles unless sw_rst_req is high in consecutive cycles.
REQ-023 Timer and index widths SHALL be sized from the parameters, with no wrap-around; the index SHALL never exceed NUM_DOMAINS-1.
REQ-024 All outputs SHALL be registered, with no combinational path from sw_rst_req to any output.

Reset
REQ-025 RST low SHALL asynchronously force state ASSERT, timer = HOLD_CYCLES-1, index = 0, dom_rst_n all 0, sw_rst_ack = 0, busy = 1, and seq_done = 0.
REQ-026 RST asserted mid-sequence or in DONE SHALL immediately re-assert every domain reset, with no acknowledge generated.

Structure
REQ-027 Shared package rst_seq_pkg SHALL hold the state encodings (ASSERT = 2'd0, RELEASE = 2'd1, DONE = 2'd2) and the parameter legal-range limits.
REQ-028 One sub-module, rst_seq_timer, SHALL implement the loadable down-counter with an expire flag; FSM, index and output registers stay in rst_seq_ctrl.

Verification
REQ-029 Defaults with RST released: dom_rst_n[0] rises at edge 4, [1] at edge 12, [2] at edge 20; seq_done and busy change at edge 20.
REQ-030 Pulse sw_rst_req for 1 cycle in DONE: next edge gives dom_rst_n = 3'b000, sw_rst_ack = 1 for 1 cycle, busy = 1; re-release follows at +4/+12/+20 edges.
REQ-031 Pulse sw_rst_req 2 cycles after dom_rst_n[0] rises: next edge gives dom_rst_n = 3'b000 and an ack pulse; full sequence restarts from hold.
REQ-032 Hold sw_rst_req high 5 cycles in ASSERT: 5 ack pulses; dom_rst_n[0] rises 4 edges after the request drops.
REQ-033 Assert RST at edge 15 (domains 0 and 1 released): dom_rst_n = 3'b000 without waiting for a clock edge, sw_rst_ack stays 0, and the sequence restarts after RST deasserts.
REQ-034 With NUM_DOMAINS = 1 and HOLD_CYCLES = 1: dom_rst_n rises and seq_done goes high at edge 1.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings, parameter limits
// and a width helper for the timer and index registers.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StAssert  = 2'd0,
        StRelease = 2'd1,
        StDone    = 2'd2
    } seq_state_e;

    localparam int unsigned NumDomainsMin = 1;
    localparam int unsigned NumDomainsMax = 8;
    localparam int unsigned HoldCyclesMin = 1;
    localparam int unsigned HoldCyclesMax = 255;
    localparam int unsigned GapCyclesMin  = 1;
    localparam int unsigned GapCyclesMax  = 255;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable saturating down-counter; expired_o is high while the count reads zero.
module rst_seq_timer
    import rst_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= WIDTH'(RESET_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets, then releases them one at a time,
// restarting the whole sequence on a software request.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 3,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   busy,
    output logic                   seq_done
);

    localparam int unsigned TimerMax =
        (HOLD_CYCLES > GAP_CYCLES) ? (HOLD_CYCLES - 1) : (GAP_CYCLES - 1);
    localparam int unsigned TimerW = cnt_width(TimerMax);
    localparam int unsigned IdxW   = cnt_width(NUM_DOMAINS - 1);

    localparam logic [TimerW-1:0] HoldLoad = TimerW'(HOLD_CYCLES - 1);
    localparam logic [TimerW-1:0] GapLoad  = TimerW'(GAP_CYCLES - 1);
    localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NUM_DOMAINS - 1);

    seq_state_e             state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   timer_load;
    logic [TimerW-1:0]      timer_val;
    logic                   timer_expired;

    rst_seq_timer #(
        .WIDTH     (TimerW),
        .RESET_VAL (HOLD_CYCLES - 1)
    ) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .expired_o  (timer_expired)
    );

    // idx_q is the next domain to release; it stops at the last domain.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dom_d      = dom_q;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        timer_load = 1'b0;
        timer_val  = HoldLoad;

        if (sw_rst_req) begin
            // A request in any state restarts the hold from scratch.
            state_d    = StAssert;
            idx_d      = '0;
            dom_d      = '0;
            ack_d      = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            timer_load = 1'b1;
            timer_val  = HoldLoad;
        end else begin
            case (state_q)
                StAssert: begin
                    if (timer_expired) begin
                        dom_d[0] = 1'b1;
                        if (NUM_DOMAINS == 1) begin
                            state_d = StDone;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = StRelease;
                            idx_d      = IdxW'(1);
                            timer_load = 1'b1;
                            timer_val  = GapLoad;
                        end
                    end
                end
                StRelease: begin
                    if (timer_expired) begin
                        for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
                            if (idx_q == IdxW'(k)) begin
                                dom_d[k] = 1'b1;
                            end
                        end
                        if (idx_q == LastIdx) begin
                            state_d = StDone;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d      = idx_q + 1'b1;
                            timer_load = 1'b1;
                            timer_val  = GapLoad;
                        end
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d    = StAssert;
                    idx_d      = '0;
                    dom_d      = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    timer_load = 1'b1;
                    timer_val  = HoldLoad;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StAssert;
            idx_q   <= '0;
            dom_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sw_rst_ack = ack_q;
    assign dom_rst_n  = dom_q;
    assign busy       = busy_q;
    assign seq_done   = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus queues expected outputs per edge,
// a monitor compares them on the falling clock edge.
module tb_rst_seq_ctrl;

    logic       CLK;
    logic       RST;
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic [2:0] dom_rst_n;
    logic       busy;
    logic       seq_done;

    logic       d1_ack;
    logic [0:0] d1_dom;
    logic       d1_busy;
    logic       d1_done;
    logic       d1_req;

    int n_err;
    int n_chk;
    int tick;

    typedef struct {
        int         at;
        logic [2:0] dom;
        bit         busy;
        bit         done;
    } exp_t;

    exp_t q[$];
    bit   exp_ack[int];

    rst_seq_ctrl #(
        .NUM_DOMAINS (3),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .sw_rst_req (sw_rst_req),
        .sw_rst_ack (sw_rst_ack),
        .dom_rst_n  (dom_rst_n),
        .busy       (busy),
        .seq_done   (seq_done)
    );

    rst_seq_ctrl #(
        .NUM_DOMAINS (1),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (8)
    ) dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .sw_rst_req (d1_req),
        .sw_rst_ack (d1_ack),
        .dom_rst_n  (d1_dom),
        .busy       (d1_busy),
        .seq_done   (d1_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial tick = 0;
    always @(posedge CLK) tick <= tick + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tick=%0d", tick);
        $fatal(1);
    end

    task automatic expect_at(input int at, input logic [2:0] dom, input bit b, input bit d);
        exp_t e;
        int   pos;
        e.at   = at;
        e.dom  = dom;
        e.busy = b;
        e.done = d;
        pos    = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].at > at) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, e);
    endtask

    // Full release sequence for defaults, timer loaded with HOLD-1 at edge s.
    task automatic expect_seq(input int s);
        expect_at(s + 1,  3'b000, 1'b1, 1'b0);
        expect_at(s + 3,  3'b000, 1'b1, 1'b0);
        expect_at(s + 4,  3'b001, 1'b1, 1'b0);
        expect_at(s + 11, 3'b001, 1'b1, 1'b0);
        expect_at(s + 12, 3'b011, 1'b1, 1'b0);
        expect_at(s + 19, 3'b011, 1'b1, 1'b0);
        expect_at(s + 20, 3'b111, 1'b0, 1'b1);
    endtask

    // Drives the request for n sampled edges starting at the next rising edge.
    task automatic pulse_req(input int n, output int first, output int last);
        first = tick + 1;
        last  = first + n - 1;
        for (int i = first; i <= last; i++) exp_ack[i] = 1'b1;
        sw_rst_req = 1'b1;
        repeat (n) @(negedge CLK);
        sw_rst_req = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (tick < t) @(negedge CLK);
    endtask

    task automatic check_now(input string nm, input logic [2:0] dom, input bit a,
                             input bit b, input bit d);
        n_chk++;
        if (dom_rst_n !== dom || sw_rst_ack !== a || busy !== b || seq_done !== d) begin
            n_err++;
            $display("FAIL %s: got dom=%b ack=%b busy=%b done=%b, want dom=%b ack=%b busy=%b done=%b",
                     nm, dom_rst_n, sw_rst_ack, busy, seq_done, dom, a, b, d);
        end
    endtask

    task automatic check_d1(input string nm, input bit dom, input bit b, input bit d);
        n_chk++;
        if (d1_dom[0] !== dom || d1_busy !== b || d1_done !== d || d1_ack !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got dom=%b busy=%b done=%b ack=%b, want dom=%b busy=%b done=%b ack=0",
                     nm, d1_dom[0], d1_busy, d1_done, d1_ack, dom, b, d);
        end
    endtask

    // Monitor: ack checked every cycle, queued entries checked on their edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            n_chk++;
            if (sw_rst_ack !== (exp_ack.exists(tick) != 0)) begin
                n_err++;
                $display("FAIL ack at tick %0d: got %b, want %0d", tick, sw_rst_ack,
                         exp_ack.exists(tick));
            end
            while (q.size() > 0 && q[0].at <= tick) begin
                e = q.pop_front();
                n_chk++;
                if (e.at != tick) begin
                    n_err++;
                    $display("FAIL missed entry for tick %0d (now %0d)", e.at, tick);
                end else if (dom_rst_n !== e.dom || busy !== e.busy || seq_done !== e.done) begin
                    n_err++;
                    $display("FAIL outputs at tick %0d: got dom=%b busy=%b done=%b, want dom=%b busy=%b done=%b",
                             tick, dom_rst_n, busy, seq_done, e.dom, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        int base, s, s2, f, l;
        n_err      = 0;
        n_chk      = 0;
        RST        = 1'b0;
        sw_rst_req = 1'b0;
        d1_req     = 1'b0;

        repeat (2) @(negedge CLK);
        check_now("reset_state", 3'b000, 1'b0, 1'b1, 1'b0);
        check_d1("d1_reset_state", 1'b0, 1'b1, 1'b0);

        // Power-on sequence: releases at edges 4, 12, 20.
        base = tick;
        expect_seq(base);
        RST = 1'b1;
        @(negedge CLK);
        check_d1("d1_edge1_release", 1'b1, 1'b0, 1'b1);
        wait_until(base + 22);

        // Single request in DONE.
        s = tick + 1;
        expect_at(s, 3'b000, 1'b1, 1'b0);
        expect_seq(s);
        pulse_req(1, f, l);
        wait_until(s + 22);

        // Abort two cycles after domain 0 releases.
        s = tick + 1;
        expect_at(s, 3'b000, 1'b1, 1'b0);
        expect_at(s + 3, 3'b000, 1'b1, 1'b0);
        expect_at(s + 4, 3'b001, 1'b1, 1'b0);
        pulse_req(1, f, l);
        wait_until(s + 5);
        s2 = tick + 1;
        expect_at(s2, 3'b000, 1'b1, 1'b0);
        expect_seq(s2);
        pulse_req(1, f, l);
        wait_until(s2 + 22);

        // Request held five cycles while in ASSERT.
        s = tick + 1;
        expect_at(s, 3'b000, 1'b1, 1'b0);
        pulse_req(1, f, l);
        @(negedge CLK);
        s = tick + 5;
        expect_at(s, 3'b000, 1'b1, 1'b0);
        expect_seq(s);
        pulse_req(5, f, l);
        wait_until(l + 22);

        // Reset in DONE drops everything without an edge.
        RST = 1'b0;
        #1;
        check_now("rst_in_done", 3'b000, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        base = tick;
        expect_at(base + 1,  3'b000, 1'b1, 1'b0);
        expect_at(base + 4,  3'b001, 1'b1, 1'b0);
        expect_at(base + 12, 3'b011, 1'b1, 1'b0);
        RST = 1'b1;
        wait_until(base + 15);
        check_now("pre_rst_edge15", 3'b011, 1'b0, 1'b1, 1'b0);
        RST = 1'b0;
        #1;
        check_now("rst_at_edge15", 3'b000, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge CLK);
        check_now("rst_held", 3'b000, 1'b0, 1'b1, 1'b0);
        base = tick;
        expect_seq(base);
        RST = 1'b1;
        @(negedge CLK);
        check_d1("d1_after_rerst", 1'b1, 1'b0, 1'b1);
        wait_until(base + 22);

        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d expected entries never checked, want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
